// File: rtl/four_way_grant_arbiter_pkg.sv
// Shared constants for the four-way round-robin grant arbiter.
package four_way_grant_arbiter_pkg;

    // Arbiter state encoding (legacy-compatible constants)
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Requester count and encoded index width
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;

endpackage

// File: rtl/four_way_grant_arbiter_decoder.sv
// 2-to-4 enable decoder: one-hot Y from W when En is high, all zero otherwise.
module two_four_decoder (
    input  logic [1:0] W,
    input  logic       En,
    output logic [3:0] Y
);

    // One-hot decode gated by the enable
    always_comb begin
        Y = '0;
        if (En) Y[W] = 1'b1;
    end

endmodule

// File: rtl/four_way_grant_arbiter.sv
// Round-robin arbiter for four requesters with a per-grant hold limit.
// The winner index is registered; the one-hot grant is decoded from it.
module four_way_grant_arbiter
    import four_way_grant_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid,
    output logic               timeout,
    output logic [IDX_W-1:0]   timeout_idx
);

    // Counter value on which the hold limit expires (unused when MAX_HOLD is 0)
    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

    logic [0:0]         state;
    logic [IDX_W-1:0]   ptr;
    logic [CNT_W-1:0]   hold_cnt;
    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] mask_next;
    logic [NUM_REQ-1:0] eligible;
    logic [IDX_W:0]     pick;
    logic               holder_req;
    logic               hold_expired;

    // First set bit of elig searching from start upward with wraparound;
    // MSB of the result flags that a winner was found.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                               input logic [IDX_W-1:0]   start);
        logic [IDX_W:0]   r;
        logic [IDX_W-1:0] cand;
        r = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = start + IDX_W'(k);
            if (!r[IDX_W] && elig[cand]) r = {1'b1, cand};
        end
        return r;
    endfunction

    // Arbitration candidates, hold-limit detection and next mask
    always_comb begin
        eligible     = req & ~mask;
        pick         = rr_pick(eligible, ptr);
        holder_req   = req[gnt_idx];
        hold_expired = (MAX_HOLD != 0) && (state == ST_BUSY) && holder_req &&
                       (hold_cnt == HOLD_LAST);
        mask_next    = mask & req;
        if (hold_expired) mask_next[gnt_idx] = 1'b1;
    end

    // Grant state machine, hold counter, mask and timeout reporting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            mask        <= '0;
            gnt_idx     <= '0;
            gnt_valid   <= 1'b0;
            timeout     <= 1'b0;
            timeout_idx <= '0;
        end else begin
            timeout <= 1'b0;
            mask    <= mask_next;
            case (state)
                ST_IDLE: begin
                    if (pick[IDX_W]) begin
                        state     <= ST_BUSY;
                        gnt_idx   <= pick[IDX_W-1:0];
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
                    end
                end
                ST_BUSY: begin
                    if (!holder_req) begin
                        state     <= ST_IDLE;
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_idx + IDX_W'(1);
                    end else if (hold_expired) begin
                        state       <= ST_IDLE;
                        gnt_valid   <= 1'b0;
                        ptr         <= gnt_idx + IDX_W'(1);
                        timeout     <= 1'b1;
                        timeout_idx <= gnt_idx;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

    two_four_decoder u_dec (
        .W  (gnt_idx),
        .En (gnt_valid),
        .Y  (gnt)
    );

endmodule

// File: tb/tb_four_way_grant_arbiter.sv
// Self-checking bench for four_way_grant_arbiter: three instances
// (MAX_HOLD = 16, 4, 0) driven from per-cycle vector tables.
module tb_four_way_grant_arbiter;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       valid;
        logic       to;
        logic [1:0] toidx;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_i  [3];
    logic [3:0] gnt_o  [3];
    logic [1:0] idx_o  [3];
    logic       val_o  [3];
    logic       to_o   [3];
    logic [1:0] tidx_o [3];

    vec_t tbl[$];
    vec_t exp_q[$];
    int   total;
    int   bad;

    four_way_grant_arbiter #(.MAX_HOLD(16), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .req(req_i[0]), .gnt(gnt_o[0]), .gnt_idx(idx_o[0]),
        .gnt_valid(val_o[0]), .timeout(to_o[0]), .timeout_idx(tidx_o[0]));

    four_way_grant_arbiter #(.MAX_HOLD(4), .CNT_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .req(req_i[1]), .gnt(gnt_o[1]), .gnt_idx(idx_o[1]),
        .gnt_valid(val_o[1]), .timeout(to_o[1]), .timeout_idx(tidx_o[1]));

    four_way_grant_arbiter #(.MAX_HOLD(0), .CNT_W(8)) u_c (
        .clk(clk), .rst_n(rst_n), .req(req_i[2]), .gnt(gnt_o[2]), .gnt_idx(idx_o[2]),
        .gnt_valid(val_o[2]), .timeout(to_o[2]), .timeout_idx(tidx_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic check(input int w, input vec_t e, input string label);
        logic ok;
        ok = (gnt_o[w] == e.gnt) && (val_o[w] == e.valid) && (to_o[w] == e.to) &&
             (tidx_o[w] == e.toidx) && (!e.valid || (idx_o[w] == e.idx));
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got gnt=%b idx=%0d valid=%b timeout=%b timeout_idx=%0d, want gnt=%b idx=%0d valid=%b timeout=%b timeout_idx=%0d",
                     label, gnt_o[w], idx_o[w], val_o[w], to_o[w], tidx_o[w],
                     e.gnt, e.idx, e.valid, e.to, e.toidx);
        end
    endtask

    // Drive one vector before the edge, then compare after the edge.
    task automatic apply(input int w, input vec_t v, input string label);
        vec_t e;
        @(negedge clk);
        req_i[w] = v.req;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(w, e, label);
    endtask

    task automatic add(input logic [3:0] r, input logic [3:0] g, input logic [1:0] ix,
                       input logic t, input logic [1:0] ti);
        vec_t v;
        v.req = r; v.gnt = g; v.idx = ix; v.valid = |g; v.to = t; v.toidx = ti;
        tbl.push_back(v);
    endtask

    task automatic run(input int w, input string name);
        for (int i = 0; i < tbl.size(); i++) apply(w, tbl[i], $sformatf("%s[%0d]", name, i));
        tbl.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) req_i[i] = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t zero;
        vec_t hold;
        logic [3:0] oh;
        total = 0;
        bad   = 0;
        zero.req = 4'b0000; zero.gnt = 4'b0000; zero.idx = 2'd0;
        zero.valid = 1'b0; zero.to = 1'b0; zero.toidx = 2'd0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) req_i[i] = 4'b0000;
        #12;
        for (int i = 0; i < 3; i++) check(i, zero, $sformatf("reset_state%0d", i));
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset while requester 2 holds the grant
        add(4'b0100, 4'b0100, 2'd2, 1'b0, 2'd0);
        add(4'b0100, 4'b0100, 2'd2, 1'b0, 2'd0);
        run(0, "hold2");
        #2;
        rst_n = 1'b0;
        req_i[0] = 4'b0000;
        #1;
        check(0, zero, "async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        add(4'b0001, 4'b0001, 2'd0, 1'b0, 2'd0);
        add(4'b0000, 4'b0000, 2'd0, 1'b0, 2'd0);
        run(0, "after_reset");

        // Round-robin with all four requesting; holder drops for one cycle
        do_reset();
        for (int k = 0; k < 4; k++) begin
            oh = 4'(1 << k);
            for (int j = 0; j < 3; j++) add(4'b1111, oh, 2'(k), 1'b0, 2'd0);
            add(4'b1111 & ~oh, 4'b0000, 2'd0, 1'b0, 2'd0);
        end
        add(4'b1111, 4'b0001, 2'd0, 1'b0, 2'd0);
        run(0, "round_robin");

        // Wraparound from ptr=3; waiting requester never preempts
        do_reset();
        add(4'b0100, 4'b0100, 2'd2, 1'b0, 2'd0);
        add(4'b0000, 4'b0000, 2'd0, 1'b0, 2'd0);
        add(4'b0011, 4'b0001, 2'd0, 1'b0, 2'd0);
        add(4'b0011, 4'b0001, 2'd0, 1'b0, 2'd0);
        add(4'b0010, 4'b0000, 2'd0, 1'b0, 2'd0);
        add(4'b0010, 4'b0010, 2'd1, 1'b0, 2'd0);
        add(4'b0000, 4'b0000, 2'd0, 1'b0, 2'd0);
        run(0, "wrap");

        // MAX_HOLD=4: single requester times out, stays masked until it drops
        do_reset();
        for (int j = 0; j < 4; j++) add(4'b0100, 4'b0100, 2'd2, 1'b0, 2'd0);
        add(4'b0100, 4'b0000, 2'd0, 1'b1, 2'd2);
        add(4'b0100, 4'b0000, 2'd0, 1'b0, 2'd2);
        add(4'b0100, 4'b0000, 2'd0, 1'b0, 2'd2);
        add(4'b0000, 4'b0000, 2'd0, 1'b0, 2'd2);
        add(4'b0100, 4'b0100, 2'd2, 1'b0, 2'd2);
        add(4'b0000, 4'b0000, 2'd0, 1'b0, 2'd2);
        run(1, "timeout");

        // MAX_HOLD=4 with a competitor: masked requester 0 is skipped
        for (int j = 0; j < 4; j++) add(4'b0101, 4'b0001, 2'd0, 1'b0, 2'd2);
        add(4'b0101, 4'b0000, 2'd0, 1'b1, 2'd0);
        add(4'b0101, 4'b0100, 2'd2, 1'b0, 2'd0);
        add(4'b0101, 4'b0100, 2'd2, 1'b0, 2'd0);
        for (int j = 0; j < 3; j++) add(4'b0001, 4'b0000, 2'd0, 1'b0, 2'd0);
        run(1, "timeout_comp");

        // Holder drops on the expiry edge: release, no timeout, no mask
        add(4'b0000, 4'b0000, 2'd0, 1'b0, 2'd0);
        for (int j = 0; j < 4; j++) add(4'b1000, 4'b1000, 2'd3, 1'b0, 2'd0);
        add(4'b0000, 4'b0000, 2'd0, 1'b0, 2'd0);
        add(4'b1000, 4'b1000, 2'd3, 1'b0, 2'd0);
        add(4'b0000, 4'b0000, 2'd0, 1'b0, 2'd0);
        run(1, "drop_vs_timeout");

        // MAX_HOLD=0: grant held for 300 cycles without any timeout
        do_reset();
        hold.req = 4'b1000; hold.gnt = 4'b1000; hold.idx = 2'd3;
        hold.valid = 1'b1; hold.to = 1'b0; hold.toidx = 2'd0;
        for (int c = 0; c < 300; c++) apply(2, hold, $sformatf("no_timeout[%0d]", c));
        apply(2, zero, "no_timeout_release");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
